// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM encoding and lap-word layout for the stopwatch blocks
package stopwatch_pkg;

    typedef enum logic [1:0] {LIVE, HOLD, BROWSE} sw_state_e;

    localparam int LAP_W   = 19;
    localparam int MS_LSB  = 0;
    localparam int MS_W    = 7;
    localparam int SEC_LSB = 7;
    localparam int SEC_W   = 6;
    localparam int MIN_LSB = 13;
    localparam int MIN_W   = 6;

    function automatic logic [LAP_W-1:0] pack_lap(input logic [MIN_W-1:0] m,
                                                  input logic [SEC_W-1:0] s,
                                                  input logic [MS_W-1:0] ms);
        return {m, s, ms};
    endfunction

endpackage

// File: rtl/lap_store.sv
// lap_store: lap word memory, synchronous write and combinational read, never cleared
module lap_store
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [LAP_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [LAP_W-1:0] rdata
);

    logic [LAP_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lap_record_ctrl.sv
// lap_record_ctrl: stopwatch lap capture, timed hold display and lap browsing
module lap_record_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int HOLD_CYCLES = 100,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          record,
    input  logic          browse,
    input  logic          clear,
    input  logic [5:0]    min_i,
    input  logic [5:0]    sec_i,
    input  logic [6:0]    ms_10_i,
    output logic [5:0]    min_o,
    output logic [5:0]    sec_o,
    output logic [6:0]    ms_10_o,
    output logic          showing_lap_o,
    output logic [AW-1:0] lap_idx_o,
    output logic [AW:0]   lap_cnt_o,
    output logic          full_o
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int HR = HOLD_CYCLES - 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HR[HW-1:0];
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    sw_state_e        state, state_n;
    logic [AW:0]      cnt, cnt_n;
    logic [AW-1:0]    idx, idx_n, raddr;
    logic [HW-1:0]    hcnt, hcnt_n;
    logic             full, accept, step;
    logic [LAP_W-1:0] rdata;

    assign full   = cnt == FULL_CNT;
    assign accept = record && !full;
    // a record pulse always masks browse, even when the record itself is refused
    assign step   = browse && !record;
    assign raddr  = (state == HOLD) ? AW'(cnt - 1'b1) : idx;

    lap_store #(.DEPTH(DEPTH)) u_store (
        .clk  (clk),
        .we   (accept && !clear && rst),
        .waddr(cnt[AW-1:0]),
        .wdata(pack_lap(min_i, sec_i, ms_10_i)),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        hcnt_n  = hcnt;
        if (clear) begin
            state_n = LIVE;
            cnt_n   = '0;
            idx_n   = '0;
            hcnt_n  = '0;
        end else begin
            if (accept) cnt_n = cnt + 1'b1;
            case (state)
                LIVE: begin
                    if (accept) begin
                        state_n = HOLD;
                        hcnt_n  = HOLD_RELOAD;
                    end else if (step && cnt != '0) begin
                        state_n = BROWSE;
                        idx_n   = '0;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        hcnt_n = HOLD_RELOAD;
                    end else if (step) begin
                        state_n = BROWSE;
                        idx_n   = '0;
                    end else if (hcnt == '0) begin
                        state_n = LIVE;
                    end else begin
                        hcnt_n = hcnt - 1'b1;
                    end
                end
                BROWSE: begin
                    if (step) begin
                        state_n = ({1'b0, idx} == cnt - 1'b1) ? LIVE : BROWSE;
                        idx_n   = ({1'b0, idx} == cnt - 1'b1) ? '0 : idx + 1'b1;
                    end
                end
                default: state_n = LIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LIVE;
            cnt   <= '0;
            idx   <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            hcnt  <= hcnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            min_o         <= '0;
            sec_o         <= '0;
            ms_10_o       <= '0;
            showing_lap_o <= 1'b0;
            lap_idx_o     <= '0;
        end else begin
            min_o         <= (state == LIVE) ? min_i : rdata[MIN_LSB +: MIN_W];
            sec_o         <= (state == LIVE) ? sec_i : rdata[SEC_LSB +: SEC_W];
            ms_10_o       <= (state == LIVE) ? ms_10_i : rdata[MS_LSB +: MS_W];
            showing_lap_o <= state != LIVE;
            lap_idx_o     <= (state == LIVE) ? '0 : raddr;
        end
    end

    assign lap_cnt_o = cnt;
    assign full_o    = full;

endmodule

// File: tb/tb_lap_record_ctrl.sv
// tb_lap_record_ctrl: directed checks of lap capture, hold, browse, clear and reset
module tb_lap_record_ctrl;

    logic       clk = 1'b0;
    logic       rst, record, browse, clear;
    logic [5:0] min_i, sec_i, min_o, sec_o;
    logic [6:0] ms_10_i, ms_10_o;
    logic       showing_lap_o, full_o;
    logic [1:0] lap_idx_o;
    logic [2:0] lap_cnt_o;
    int         n_chk = 0;
    int         n_err = 0;
    int         exp_min [3] = '{10, 11, 12};

    lap_record_ctrl #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .record       (record),
        .browse       (browse),
        .clear        (clear),
        .min_i        (min_i),
        .sec_i        (sec_i),
        .ms_10_i      (ms_10_i),
        .min_o        (min_o),
        .sec_o        (sec_o),
        .ms_10_o      (ms_10_o),
        .showing_lap_o(showing_lap_o),
        .lap_idx_o    (lap_idx_o),
        .lap_cnt_o    (lap_cnt_o),
        .full_o       (full_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_live(input int m, input int s, input int ms);
        min_i   = 6'(m);
        sec_i   = 6'(s);
        ms_10_i = 7'(ms);
    endtask

    task automatic disp(input string tag, input int m, input int s, input int ms, input int sh);
        chk({tag, ".min"}, 32'(min_o), 32'(m));
        chk({tag, ".sec"}, 32'(sec_o), 32'(s));
        chk({tag, ".ms"}, 32'(ms_10_o), 32'(ms));
        chk({tag, ".show"}, 32'(showing_lap_o), 32'(sh));
    endtask

    task automatic pulse_browse();
        browse = 1'b1;
        tick();
        browse = 1'b0;
    endtask

    initial begin
        rst = 1'b0; record = 1'b0; browse = 1'b0; clear = 1'b0;
        set_live(7, 8, 9);
        tick(); tick();
        disp("rst", 0, 0, 0, 0);
        chk("rst.idx", 32'(lap_idx_o), 0);
        chk("rst.cnt", 32'(lap_cnt_o), 0);
        chk("rst.full", 32'(full_o), 0);
        rst = 1'b1;
        tick();
        disp("live", 7, 8, 9, 0);

        // single capture then 4-cycle hold
        set_live(1, 2, 3);
        record = 1'b1; tick(); record = 1'b0;
        chk("t1.cnt", 32'(lap_cnt_o), 1);
        chk("t1.show0", 32'(showing_lap_o), 0);
        set_live(5, 6, 7);
        for (int i = 0; i < 4; i++) begin
            tick();
            disp("t1.hold", 1, 2, 3, 1);
            chk("t1.idx", 32'(lap_idx_o), 0);
        end
        tick();
        disp("t1.back", 5, 6, 7, 0);

        // record and browse together in LIVE
        set_live(20, 30, 40);
        record = 1'b1; browse = 1'b1; tick(); record = 1'b0; browse = 1'b0;
        chk("t4.cnt", 32'(lap_cnt_o), 2);
        tick();
        disp("t4.hold", 20, 30, 40, 1);
        chk("t4.idx", 32'(lap_idx_o), 1);
        repeat (4) tick();
        chk("t4.live", 32'(showing_lap_o), 0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr.cnt", 32'(lap_cnt_o), 0);

        // record again at hold cycle 2
        set_live(10, 20, 30);
        record = 1'b1; tick(); record = 1'b0;
        tick();
        disp("t6.first", 10, 20, 30, 1);
        set_live(11, 21, 31);
        record = 1'b1; tick(); record = 1'b0;
        chk("t6.cnt", 32'(lap_cnt_o), 2);
        disp("t6.edge", 10, 20, 30, 1);
        set_live(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            disp("t6.hold", 11, 21, 31, 1);
            chk("t6.idx", 32'(lap_idx_o), 1);
        end
        tick();
        disp("t6.back", 0, 0, 1, 0);

        // browse through 3 laps
        set_live(12, 22, 32);
        record = 1'b1; tick(); record = 1'b0;
        chk("t3.cnt", 32'(lap_cnt_o), 3);
        repeat (5) tick();
        chk("t3.live", 32'(showing_lap_o), 0);
        pulse_browse();
        chk("t3.b0", 32'(showing_lap_o), 0);
        for (int k = 0; k < 3; k++) begin
            pulse_browse();
            chk("t3.idx", 32'(lap_idx_o), 32'(k));
            chk("t3.min", 32'(min_o), 32'(exp_min[k]));
            chk("t3.show", 32'(showing_lap_o), 1);
        end
        tick();
        chk("t3.exit", 32'(showing_lap_o), 0);
        chk("t3.exitidx", 32'(lap_idx_o), 0);

        // reset while browsing at idx 2
        pulse_browse(); pulse_browse(); pulse_browse();
        chk("rb.show", 32'(showing_lap_o), 1);
        rst = 1'b0; tick();
        disp("rb", 0, 0, 0, 0);
        chk("rb.idx", 32'(lap_idx_o), 0);
        chk("rb.cnt", 32'(lap_cnt_o), 0);
        rst = 1'b1;
        set_live(3, 4, 5);
        tick();
        disp("rb.live", 3, 4, 5, 0);
        pulse_browse();
        tick();
        chk("empty.browse", 32'(showing_lap_o), 0);

        // fill, then one record too many
        for (int k = 0; k < 4; k++) begin
            set_live(k + 1, k + 2, k + 3);
            record = 1'b1;
            tick();
        end
        record = 1'b0;
        chk("t2.cnt", 32'(lap_cnt_o), 4);
        chk("t2.full", 32'(full_o), 1);
        set_live(50, 50, 50);
        record = 1'b1; tick(); record = 1'b0;
        chk("t2.cnt5", 32'(lap_cnt_o), 4);
        chk("t2.full5", 32'(full_o), 1);
        disp("t2.slot3", 4, 5, 6, 1);
        chk("t2.idx", 32'(lap_idx_o), 3);

        // clear beats record
        record = 1'b1; clear = 1'b1; tick(); record = 1'b0; clear = 1'b0;
        chk("cr.cnt", 32'(lap_cnt_o), 0);
        chk("cr.full", 32'(full_o), 0);
        tick();
        disp("cr.live", 50, 50, 50, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
